// File: rtl/avalon_pio_pkg.sv
// Shared definitions for the Avalon-MM input PIO.
// Contents:
//   - word offsets of the slave register map
//   - edge-capture polarity selectors used by the EDGE_TYPE parameter
//   - cnt_width(): debounce counter width, never narrower than one bit
package avalon_pio_pkg;

    localparam logic [1:0] ADDR_DATA     = 2'd0;
    localparam logic [1:0] ADDR_DIR      = 2'd1;
    localparam logic [1:0] ADDR_IRQ_MASK = 2'd2;
    localparam logic [1:0] ADDR_EDGE_CAP = 2'd3;

    localparam int EDGE_RISING  = 0;
    localparam int EDGE_FALLING = 1;
    localparam int EDGE_ANY     = 2;

    // clog2(cycles+1), clamped to 1 so a zero-width vector is never declared.
    function automatic int cnt_width(input int cycles);
        return (cycles < 2) ? 1 : $clog2(cycles + 1);
    endfunction

endpackage

// File: rtl/pio_debounce.sv
// Single-bit debouncer for an already-synchronized input.
// The stable value follows the sample only after DEBOUNCE_CYCLES consecutive
// samples that disagree with it; any sample agreeing with the stable value
// restarts the count. DEBOUNCE_CYCLES = 0 makes this a plain register.
// Ports:
//   clk      in   system clock
//   reset    in   synchronous active-high reset
//   sample_i in   synchronized input bit
//   stable_o out  debounced value
module pio_debounce
    import avalon_pio_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic sample_i,
    output logic stable_o
);

    logic stable_q;

    generate
        if (DEBOUNCE_CYCLES == 0) begin : g_bypass
            always_ff @(posedge clk) begin
                if (reset) stable_q <= 1'b0;
                else       stable_q <= sample_i;
            end
        end else begin : g_count
            localparam int              CW   = cnt_width(DEBOUNCE_CYCLES);
            localparam logic [CW-1:0]   LAST = CW'(DEBOUNCE_CYCLES - 1);

            logic [CW-1:0] cnt_q;

            // The count starts on the first disagreeing sample, so the value
            // flips on the DEBOUNCE_CYCLES-th one (when the count is LAST).
            always_ff @(posedge clk) begin
                if (reset) begin
                    cnt_q    <= '0;
                    stable_q <= 1'b0;
                end else if (sample_i == stable_q) begin
                    cnt_q    <= '0;
                end else if (cnt_q == LAST) begin
                    cnt_q    <= '0;
                    stable_q <= sample_i;
                end else begin
                    cnt_q    <= cnt_q + 1'b1;
                end
            end
        end
    endgenerate

    assign stable_o = stable_q;

endmodule

// File: rtl/avalon_input_pio.sv
// Avalon-MM slave input port: samples external inputs (switches, keys) through
// a 2-FF synchronizer and per-bit debouncer, captures edges of the debounced
// value and raises a maskable level interrupt.
// Register map (word offsets): 0 DATA (RO), 1 reserved (reads 0),
// 2 IRQ_MASK (RW), 3 EDGE_CAPTURE (write-1-to-clear).
// Ports:
//   clk        in   system clock
//   reset      in   synchronous active-high reset
//   address    in   register select
//   chipselect in   slave select
//   write_n    in   active-low write strobe
//   writedata  in   write data, bits above WIDTH ignored
//   in_port    in   asynchronous external inputs
//   readdata   out  registered read data, read latency 1
//   irq        out  interrupt request, active-high
module avalon_input_pio
    import avalon_pio_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int EDGE_TYPE       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    logic [WIDTH-1:0] sync1_q, sync2_q;
    logic [WIDTH-1:0] db;
    logic [WIDTH-1:0] db_prev_q;
    logic [WIDTH-1:0] evt;
    logic [WIDTH-1:0] clr;
    logic [WIDTH-1:0] cap_q, cap_d;
    logic [WIDTH-1:0] mask_q, mask_d;
    logic             irq_q, irq_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             wr_en;

    generate
        for (genvar i = 0; i < WIDTH; i++) begin : g_db
            pio_debounce #(
                .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
            ) u_db (
                .clk      (clk),
                .reset    (reset),
                .sample_i (sync2_q[i]),
                .stable_o (db[i])
            );
        end

        if (WIDTH < 32) begin : g_wdata_hi
            logic unused_wdata_hi;
            assign unused_wdata_hi = ^writedata[31:WIDTH];
        end
    endgenerate

    assign wr_en = chipselect & ~write_n;

    always_comb begin
        if (EDGE_TYPE == EDGE_FALLING)  evt = ~db & db_prev_q;
        else if (EDGE_TYPE == EDGE_ANY) evt = db ^ db_prev_q;
        else                            evt = db & ~db_prev_q;
    end

    always_comb begin
        mask_d = mask_q;
        clr    = '0;
        if (wr_en && address == ADDR_IRQ_MASK) mask_d = writedata[WIDTH-1:0];
        if (wr_en && address == ADDR_EDGE_CAP) clr    = writedata[WIDTH-1:0];
        // Event is OR-ed in after the clear so a coincident edge is kept.
        cap_d = (cap_q & ~clr) | evt;
        irq_d = |(cap_d & mask_d);

        // Mux uses current register values: a clearing read sees pre-clear data.
        readdata_d = '0;
        case (address)
            ADDR_DATA:     readdata_d[WIDTH-1:0] = db;
            ADDR_IRQ_MASK: readdata_d[WIDTH-1:0] = mask_q;
            ADDR_EDGE_CAP: readdata_d[WIDTH-1:0] = cap_q;
            default:       readdata_d            = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            db_prev_q  <= '0;
            cap_q      <= '0;
            mask_q     <= '0;
            irq_q      <= 1'b0;
            readdata_q <= '0;
        end else begin
            sync1_q    <= in_port;
            sync2_q    <= sync1_q;
            db_prev_q  <= db;
            cap_q      <= cap_d;
            mask_q     <= mask_d;
            irq_q      <= irq_d;
            readdata_q <= readdata_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_avalon_input_pio.sv
module tb_avalon_input_pio;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [7:0]  in_port;
    logic [31:0] readdata;
    logic        irq;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    avalon_input_pio #(
        .WIDTH           (8),
        .DEBOUNCE_CYCLES (4),
        .EDGE_TYPE       (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .in_port    (in_port),
        .readdata   (readdata),
        .irq        (irq)
    );

    typedef struct {
        logic        cs;
        logic        wr;
        logic [1:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_irq;
    } vec_t;

    vec_t vecs[13];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_read(input logic [1:0] a);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        writedata  = 32'h0;
    endtask

    task automatic set_write(input logic [1:0] a, input logic [31:0] d);
        chipselect = 1'b1;
        write_n    = 1'b0;
        address    = a;
        writedata  = d;
    endtask

    initial begin
        //                cs    wr    addr   wdata           exp_rd        exp_irq
        vecs[0]  = '{1'b1, 1'b1, 2'd2, 32'hFFFF_FF3C, 32'h0000_0000, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 2'd2, 32'h0000_0000, 32'h0000_003C, 1'b0};
        vecs[2]  = '{1'b1, 1'b0, 2'd1, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[3]  = '{1'b1, 1'b1, 2'd1, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};
        vecs[4]  = '{1'b1, 1'b0, 2'd1, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 2'd0, 32'h0000_00FF, 32'h0000_0000, 1'b0};
        vecs[6]  = '{1'b1, 1'b0, 2'd0, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 2'd2, 32'h0000_00FF, 32'h0000_003C, 1'b0};
        vecs[8]  = '{1'b1, 1'b0, 2'd2, 32'h0000_0000, 32'h0000_003C, 1'b0};
        vecs[9]  = '{1'b1, 1'b1, 2'd2, 32'hFFFF_FF01, 32'h0000_003C, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 2'd2, 32'h0000_0000, 32'h0000_0001, 1'b0};
        vecs[11] = '{1'b1, 1'b0, 2'd3, 32'h0000_0000, 32'h0000_0000, 1'b0};
        vecs[12] = '{1'b1, 1'b1, 2'd3, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0};

        reset      = 1'b1;
        in_port    = 8'h00;
        chipselect = 1'b0;
        write_n    = 1'b1;
        address    = 2'd0;
        writedata  = 32'h0;
        tick();
        tick();
        check("reset readdata", readdata, 32'h0);
        check("reset irq", {31'h0, irq}, 32'h0);
        reset = 1'b0;

        set_read(2'd0); tick(); check("post-reset DATA", readdata, 32'h0);
        set_read(2'd2); tick(); check("post-reset IRQ_MASK", readdata, 32'h0);
        set_read(2'd3); tick(); check("post-reset EDGE_CAP", readdata, 32'h0);
        check("post-reset irq", {31'h0, irq}, 32'h0);

        // Register access vectors with in_port idle; readdata shows the value
        // selected in the cycle the access was presented.
        for (int i = 0; i < 13; i++) begin
            chipselect = vecs[i].cs;
            write_n    = ~vecs[i].wr;
            address    = vecs[i].addr;
            writedata  = vecs[i].wdata;
            tick();
            check($sformatf("vec%0d readdata", i), readdata, vecs[i].exp_rd);
            check($sformatf("vec%0d irq", i), {31'h0, irq}, {31'h0, vecs[i].exp_irq});
        end

        // 3-cycle glitch on bit 0 is one sample short of the debounce window.
        set_read(2'd0);
        in_port = 8'h01;
        repeat (3) tick();
        in_port = 8'h00;
        for (int k = 0; k < 10; k++) begin
            tick();
            check($sformatf("glitch DATA t%0d", k), readdata, 32'h0);
        end
        set_read(2'd3); tick();
        check("glitch EDGE_CAP", readdata, 32'h0);
        check("glitch irq", {31'h0, irq}, 32'h0);

        // 0x00 -> 0xA5: debounced value changes on the 6th edge, visible on the 7th read.
        set_read(2'd0);
        in_port = 8'hA5;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check($sformatf("debounce DATA edge%0d", k), readdata, (k == 7) ? 32'h0000_00A5 : 32'h0);
        end
        check("rising not captured irq", {31'h0, irq}, 32'h0);
        set_read(2'd3); tick();
        check("rising not captured EDGE_CAP", readdata, 32'h0);

        // Bit 0 falls (mask = 0x01): capture and irq on edge 7, read shows it on edge 8.
        in_port = 8'hA4;
        for (int k = 1; k <= 8; k++) begin
            tick();
            check($sformatf("fall irq edge%0d", k), {31'h0, irq}, (k >= 7) ? 32'h1 : 32'h0);
            check($sformatf("fall EDGE_CAP edge%0d", k), readdata, (k >= 8) ? 32'h1 : 32'h0);
        end

        set_write(2'd3, 32'hFFFF_FF01); tick();
        check("W1C pre-clear read", readdata, 32'h0000_0001);
        check("W1C irq", {31'h0, irq}, 32'h0);
        set_read(2'd3); tick();
        check("W1C post-clear read", readdata, 32'h0);

        // Bit 2 falls; the W1C of bit 2 lands in the same cycle as the event.
        in_port = 8'hA0;
        repeat (6) tick();
        set_write(2'd3, 32'h0000_0004); tick();
        check("coincident pre read", readdata, 32'h0);
        set_read(2'd3); tick();
        check("coincident EDGE_CAP", readdata, 32'h0000_0004);
        check("coincident irq masked", {31'h0, irq}, 32'h0);

        // Build cap = 0x10 via a rise then fall on bit 4, then unmask everything.
        set_write(2'd3, 32'h0000_00FF); tick();
        set_read(2'd3);
        in_port = 8'hB0;
        repeat (8) tick();
        in_port = 8'hA0;
        repeat (8) tick();
        set_write(2'd2, 32'h0000_00FF); tick();
        check("pending irq", {31'h0, irq}, 32'h1);
        set_read(2'd3); tick();
        check("pending EDGE_CAP", readdata, 32'h0000_0010);
        set_read(2'd2); tick();
        check("pending IRQ_MASK", readdata, 32'h0000_00FF);

        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("reset clears irq", {31'h0, irq}, 32'h0);
        check("reset clears readdata", readdata, 32'h0);
        set_read(2'd2); tick(); check("after reset IRQ_MASK", readdata, 32'h0);
        set_read(2'd3); tick(); check("after reset EDGE_CAP", readdata, 32'h0);
        set_read(2'd0); tick(); check("after reset DATA", readdata, 32'h0);
        check("after reset irq", {31'h0, irq}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
